// File: rtl/mux41_arb_pkg.sv
// Shared definitions for the rotating-priority 4:1 arbiter/mux:
// FSM state encoding, default parameters and requester count.
package mux41_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search over four requests: the first set bit found
// walking upward from ptr (modulo 4) wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk offsets from far to near so the nearest requester is written last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_arb.sv
// 4:1 data mux whose select is owned by a rotating-priority arbiter; each
// grant lasts until the owner drops its request or P_MAX_HOLD beats pass.
module mux41_rr_arb
    import mux41_arb_pkg::*;
#(
    parameter int P_WIDTH    = DEF_WIDTH,
    parameter int P_MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [P_WIDTH-1:0]   i_d_0,
    input  logic [P_WIDTH-1:0]   i_d_1,
    input  logic [P_WIDTH-1:0]   i_d_2,
    input  logic [P_WIDTH-1:0]   i_d_3,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [1:0]           o_sel,
    output logic [P_WIDTH-1:0]   o_y,
    output logic                 o_valid,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(P_MAX_HOLD + 1);

    state_t               state;
    state_t               state_next;
    logic [1:0]           r_ptr;
    logic [1:0]           ptr_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [NUM_REQ-1:0]   gnt_next;
    logic [1:0]           sel_next;
    logic [P_WIDTH-1:0]   y_next;
    logic                 valid_next;
    logic [P_WIDTH-1:0]   mux_data;
    logic                 beat;
    logic                 release_now;
    logic [1:0]           pick_ptr;
    logic                 pick_found;
    logic [1:0]           pick_idx;

    // While granted, arbitration only matters on release, where the owner
    // must rank last, so the search starts just past it.
    assign pick_ptr = (state == ST_GRANT) ? o_sel + 2'd1 : r_ptr;

    rr_pick4 u_pick (
        .req   (i_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        case (o_sel)
            2'd0:    mux_data = i_d_0;
            2'd1:    mux_data = i_d_1;
            2'd2:    mux_data = i_d_2;
            default: mux_data = i_d_3;
        endcase
    end

    assign o_busy = (state == ST_GRANT);

    always_comb begin
        state_next  = state;
        ptr_next    = r_ptr;
        cnt_next    = cnt;
        gnt_next    = o_gnt;
        sel_next    = o_sel;
        y_next      = o_y;
        valid_next  = 1'b0;
        beat        = 1'b0;
        release_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANT;
                    sel_next   = pick_idx;
                    gnt_next   = 4'(1) << pick_idx;
                    cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                beat = i_req[o_sel];
                if (beat) begin
                    y_next      = mux_data;
                    valid_next  = 1'b1;
                    cnt_next    = cnt + CNT_W'(1);
                    release_now = (cnt_next == CNT_W'(P_MAX_HOLD));
                end else begin
                    release_now = 1'b1;
                end
                // Hand over at the same edge so a waiting requester sees no idle gap.
                if (release_now) begin
                    ptr_next = pick_ptr;
                    cnt_next = '0;
                    if (pick_found) begin
                        sel_next = pick_idx;
                        gnt_next = 4'(1) << pick_idx;
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            r_ptr   <= 2'd0;
            cnt     <= '0;
            o_gnt   <= '0;
            o_sel   <= 2'd0;
            o_y     <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_next;
            r_ptr   <= ptr_next;
            cnt     <= cnt_next;
            o_gnt   <= gnt_next;
            o_sel   <= sel_next;
            o_y     <= y_next;
            o_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Self-checking bench for mux41_rr_arb: directed vector table for the
// documented corner sequences, then random traffic against a behavioural model.
module tb_mux41_rr_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] y;
    logic       valid;
    logic       busy;

    int passed;
    int total;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] y;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: owner index (-1 when idle), beats taken, pointer.
    int         m_owner;
    int         m_beats;
    int         m_ptr;
    int         m_sel;
    logic [7:0] m_y;
    logic       m_valid;

    mux41_rr_arb #(.P_WIDTH(8), .P_MAX_HOLD(4)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_d_0   (d0),
        .i_d_1   (d1),
        .i_d_2   (d2),
        .i_d_3   (d3),
        .o_gnt   (gnt),
        .o_sel   (sel),
        .o_y     (y),
        .o_valid (valid),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add_vec(input logic r, input logic [3:0] rq, input logic [3:0] g,
                           input logic [1:0] s, input logic v, input logic [7:0] yy,
                           input logic b);
        vec_t e;
        e.rst = r; e.req = rq; e.gnt = g; e.sel = s; e.valid = v; e.y = yy; e.busy = b;
        vecs.push_back(e);
    endtask

    task automatic apply_stimulus(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] rq, input int ptr);
        for (int k = 0; k < 4; k++)
            if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [7:0] data_of(input int n);
        case (n)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        int w;
        logic rel;
        if (rst) begin
            m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0; m_y = 8'h00; m_valid = 1'b0;
        end else if (m_owner < 0) begin
            m_valid = 1'b0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_beats = 0;
            end
        end else begin
            rel = 1'b1;
            if (req[m_owner]) begin
                m_y = data_of(m_owner);
                m_valid = 1'b1;
                m_beats++;
                rel = (m_beats == 4);
            end else begin
                m_valid = 1'b0;
            end
            if (rel) begin
                m_ptr = (m_owner + 1) % 4;
                m_beats = 0;
                w = pick(req, m_ptr);
                m_owner = w;
                if (w >= 0) m_sel = w;
            end
        end
    endtask

    initial begin
        int nx;
        int cur;
        passed = 0;
        total = 0;
        rst = 1'b1;
        req = 4'b0000;
        d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;

        // Sole requester: one-cycle grant latency, re-grant after 4 beats, then idle.
        add_vec(1, 4'b0000, 4'b0000, 0, 0, 8'h00, 0);
        add_vec(0, 4'b0001, 4'b0001, 0, 0, 8'h00, 1);
        for (int b = 0; b < 5; b++) add_vec(0, 4'b0001, 4'b0001, 0, 1, 8'h10, 1);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 8'h10, 0);
        add_vec(0, 4'b0000, 4'b0000, 0, 0, 8'h10, 0);

        // All requesting: strict rotation with 4 beats each.
        add_vec(1, 4'b1111, 4'b0000, 0, 0, 8'h00, 0);
        add_vec(0, 4'b1111, 4'b0001, 0, 0, 8'h00, 1);
        for (int o = 0; o < 4; o++) begin
            for (int b = 1; b <= 4; b++) begin
                nx = (o + 1) % 4;
                cur = (b == 4) ? nx : o;
                add_vec(0, 4'b1111, 4'(1 << cur), 2'(cur), 1, 8'(16 + o), 1);
            end
        end
        add_vec(0, 4'b1111, 4'b0001, 0, 1, 8'h10, 1);

        // Owner 2 drops after 2 beats with requester 0 waiting.
        add_vec(1, 4'b0100, 4'b0000, 0, 0, 8'h00, 0);
        add_vec(0, 4'b0100, 4'b0100, 2, 0, 8'h00, 1);
        add_vec(0, 4'b0101, 4'b0100, 2, 1, 8'h12, 1);
        add_vec(0, 4'b0101, 4'b0100, 2, 1, 8'h12, 1);
        add_vec(0, 4'b0001, 4'b0001, 0, 0, 8'h12, 1);
        add_vec(0, 4'b0001, 4'b0001, 0, 1, 8'h10, 1);

        // Reset mid-grant of owner 3, then the pointer restarts at 0.
        add_vec(1, 4'b1000, 4'b0000, 0, 0, 8'h00, 0);
        add_vec(0, 4'b1000, 4'b1000, 3, 0, 8'h00, 1);
        add_vec(0, 4'b1000, 4'b1000, 3, 1, 8'h13, 1);
        add_vec(1, 4'b1010, 4'b0000, 0, 0, 8'h00, 0);
        add_vec(0, 4'b1010, 4'b0010, 1, 0, 8'h00, 1);
        add_vec(0, 4'b1010, 4'b0010, 1, 1, 8'h11, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].req);
            check($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vecs[i].gnt));
            check($sformatf("vec%0d_sel", i),   32'(sel),   32'(vecs[i].sel));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_y", i),     32'(y),     32'(vecs[i].y));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].busy));
        end

        // Random traffic; requests mostly held so grants run to their limit.
        rst = 1'b1;
        req = 4'b0000;
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            d0 = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            d2 = 8'($urandom_range(0, 255));
            d3 = 8'($urandom_range(0, 255));
            model_step();
            @(posedge clk);
            #1;
            check("rnd_gnt",   32'(gnt),   (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
            check("rnd_sel",   32'(sel),   32'(m_sel));
            check("rnd_valid", 32'(valid), 32'(m_valid));
            check("rnd_y",     32'(y),     32'(m_y));
            check("rnd_busy",  32'(busy),  32'(m_owner >= 0));
            check("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            if (busy) check("rnd_gnt_sel", 32'(gnt), 32'(4'(1) << sel));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
